// File: rtl/tart_aq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tart_aq_pkg
//  Purpose  : Shared acquisition constants and state encoding for the capture
//             FIFO and the SDRAM FIFO scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package tart_aq_pkg;

    localparam int AQ_DATA_WIDTH = 24;
    localparam int AQ_ADDR_WIDTH = 7;
    localparam int AQ_BLOCKSIZE  = 32;

    typedef enum logic [1:0] {
        AQ_IDLE    = 2'd0,
        AQ_CAPTURE = 2'd1,
        AQ_HALTED  = 2'd2
    } aq_state_t;

endpackage
`default_nettype wire

// File: rtl/aq_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module   : aq_fifo_ram
//  Purpose  : Simple dual-port sample RAM with a registered read port; a read
//             of the address being written returns the old word.
//  Revision : 1.0 - initial release
// ============================================================================
module aq_fifo_ram
    import tart_aq_pkg::*;
#(
    parameter int DATA_WIDTH = AQ_DATA_WIDTH,
    parameter int ADDR_WIDTH = AQ_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register reset maps onto the block-RAM output latch reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/aq_capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : aq_capture_fifo
//  Purpose  : Start-gated antenna sample capture into a 128-word FIFO drained
//             by the SDRAM scheduler. Option: AQ_TEST_PATTERN_EN writes a
//             counter (0,1,2,...) instead of antenna_data.
//  Revision : 1.0 - initial release
// ============================================================================
module aq_capture_fifo
    import tart_aq_pkg::*;
#(
    parameter int DATA_WIDTH = AQ_DATA_WIDTH,
    parameter int ADDR_WIDTH = AQ_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_start_aq,
    input  logic                  sample_en,
    input  logic [DATA_WIDTH-1:0] antenna_data,
    input  logic                  aq_read_en,
    output logic [DATA_WIDTH-1:0] aq_read_data,
    output logic                  aq_read_valid,
    output logic [7:0]            status_cnt,
    output logic                  aq_write_en,
    output logic                  aq_overflow,
    output logic [1:0]            aq_state
);

    localparam int c_PTR_W = ADDR_WIDTH + 1;

    logic [1:0]            sync_q, sync_d;
    aq_state_t             state_q, state_d;
    logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0]    cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  w_start_int;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_try;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic                  w_drop;
    logic [DATA_WIDTH-1:0] w_wr_data;

    always_comb begin
        sync_d      = {sync_q[0], spi_start_aq};
        w_start_int = sync_q[1];
        w_empty     = (cnt_q == '0);
        // Occupancy never exceeds the depth, so the MSB alone flags full.
        w_full      = cnt_q[ADDR_WIDTH];
        w_rd_fire   = aq_read_en && !w_empty;
        w_wr_try    = (state_q == AQ_CAPTURE) && sample_en;
        w_wr_fire   = w_wr_try && (!w_full || w_rd_fire);
        w_drop      = w_wr_try && !w_wr_fire;

        wr_ptr_d    = w_wr_fire ? wr_ptr_q + c_PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = w_rd_fire ? rd_ptr_q + c_PTR_W'(1) : rd_ptr_q;
        cnt_d       = wr_ptr_d - rd_ptr_d;
        ovf_d       = ovf_q | w_drop;
        rd_valid_d  = w_rd_fire;
    end

    // A dropped sample halts capture until start is cycled through IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            AQ_IDLE: begin
                if (w_start_int) begin
                    state_d = AQ_CAPTURE;
                end
            end
            AQ_CAPTURE: begin
                if (!w_start_int) begin
                    state_d = AQ_IDLE;
                end else if (w_drop) begin
                    state_d = AQ_HALTED;
                end
            end
            AQ_HALTED: begin
                if (!w_start_int) begin
                    state_d = AQ_IDLE;
                end
            end
            default: state_d = AQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= AQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef AQ_TEST_PATTERN_EN
    logic [DATA_WIDTH-1:0] pat_q, pat_d;
    logic                  w_unused_antenna;

    always_comb begin
        pat_d = w_wr_fire ? pat_q + DATA_WIDTH'(1) : pat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= '0;
        end else begin
            pat_q <= pat_d;
        end
    end

    assign w_wr_data        = pat_q;
    assign w_unused_antenna = ^antenna_data;
`else
    assign w_wr_data = antenna_data;
`endif

    aq_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_fire),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (w_wr_data),
        .rd_en   (w_rd_fire),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (aq_read_data)
    );

    assign aq_read_valid = rd_valid_q;
    assign status_cnt    = 8'(cnt_q);
    assign aq_write_en   = (state_q == AQ_CAPTURE);
    assign aq_overflow   = ovf_q;
    assign aq_state      = state_q;

endmodule
`default_nettype wire

// File: doc/aq_capture_fifo.md
# aq_capture_fifo

Acquisition front end for the TART correlator capture path. It takes the 24-bit antenna sample word, gates it with the SPI start command, and buffers samples in an on-chip FIFO. It presents the occupancy count and single-word read port that the SDRAM FIFO scheduler drains in 32-word blocks. It is the stage directly upstream of the scheduler's `status_cnt` / `aq_read_en` interface.

## Interface
Parameters:
- `DATA_WIDTH`, 24: antenna sample word width.
- `ADDR_WIDTH`, 7: FIFO address bits; depth = 2**ADDR_WIDTH = 128.

Ports:
- `clk` in 1: single clock.
  - Reset is synchronous and active-high (`rst`).
  - All logic is on `posedge clk`.
- `rst` in 1: synchronous, active-high reset.
- `spi_start_aq` in 1: capture-enable level from the SPI register block. Asynchronous source; synchronised internally.
- `sample_en` in 1: one-cycle strobe; `antenna_data` is valid this cycle.
- `antenna_data` in DATA_WIDTH: sample word.
- `aq_read_en` in 1: read one word (scheduler side).
- `aq_read_data` out DATA_WIDTH: registered read word.
- `aq_read_valid` out 1: `aq_read_data` is valid this cycle.
- `status_cnt` out 8: FIFO occupancy, 0..128.
- `aq_write_en` out 1: high while in CAPTURE.
- `aq_overflow` out 1: sticky; a sample was dropped because the FIFO was full.
- `aq_state` out 2: current state, for debug and SPI readback.

## Operation
- Start synchroniser:
  - 2-flop chain `sync[1:0]` on `spi_start_aq`.
  - `start_int = sync[1]`.
- State machine:
  - IDLE = 0, CAPTURE = 1, HALTED = 2.
  - IDLE → CAPTURE when `start_int` = 1.
  - CAPTURE → HALTED when a write is attempted while `status_cnt == 128`.
  - CAPTURE or HALTED → IDLE when `start_int` = 0.
  - HALTED → CAPTURE only via IDLE: the start must be deasserted and reasserted.
- Write:
  - Occurs at the edge where `state == CAPTURE`, `sample_en` = 1, and the FIFO is not full (`wr_ptr++`).
  - In IDLE and HALTED, `sample_en` is ignored.
- Read:
  - Occurs at the edge where `aq_read_en` = 1 and the FIFO is not empty (`rd_ptr++`).
  - Read on empty: ignored, `aq_read_valid` stays 0, pointers and count unchanged.
- Pointers:
  - `wr_ptr` and `rd_ptr` are ADDR_WIDTH+1 bits; they wrap naturally mod 256.
  - `status_cnt = wr_ptr - rd_ptr` (8-bit); full = 128, empty = 0.
  - `status_cnt` is a register updated in the same edge as the pointers.
- Simultaneous write and read:
  - Both are performed and the count is unchanged.
  - When full, the read frees a slot, so the write is accepted and no overflow occurs.
  - When empty, the read is ignored and the write is accepted; count becomes 1.
- Overflow:
  - Set when a write is attempted in CAPTURE while full and no read happens the same edge.
  - The sample is dropped.
  - Cleared only by `rst`; leaving CAPTURE does not clear it.
- Reset mid-operation: FIFO contents are discarded and the pointers are zeroed.

## Timing
- Reset values:
  - `aq_read_data` = 0, `aq_read_valid` = 0, `status_cnt` = 0.
  - `aq_write_en` = 0, `aq_overflow` = 0, `aq_state` = IDLE, `sync` = 0.
- Start latency:
  - `spi_start_aq` is sampled high at edge n; `sync[1]` is 1 after edge n+1.
  - `aq_state` = CAPTURE and `aq_write_en` = 1 after edge n+2.
  - The first sample accepted is one with `sample_en` at edge n+3 or later.
- Write-to-count: a write at edge k gives `status_cnt` +1 visible after edge k.
- Read latency:
  - `aq_read_en` high at edge k gives `aq_read_data` and `aq_read_valid` = 1 after edge k.
  - Valid for one cycle, then `aq_read_valid` returns to 0.
- Back-to-back operation: `aq_read_en` may be held high for consecutive cycles, giving one word per cycle.
- Data ordering: words are strictly in write order; there are no bubbles inside the FIFO.

## Configuration
- `AQ_TEST_PATTERN_EN` defined: the written word is an internal DATA_WIDTH counter instead of `antenna_data`.
  - The counter resets to 0 and increments on every accepted write.
  - Data is therefore 0, 1, 2, … for SDRAM/TX path checks.
- `AQ_TEST_PATTERN_EN` undefined: `antenna_data` is written, and the counter logic is absent.

## Structure
- Shared package `tart_aq_pkg`:
  - State encodings `AQ_IDLE`, `AQ_CAPTURE`, `AQ_HALTED`.
  - `AQ_DATA_WIDTH` = 24, `AQ_ADDR_WIDTH` = 7.
  - `AQ_BLOCKSIZE` = 32, shared with the scheduler.
- Sub-module `aq_fifo_ram`: simple dual-port 128×24 RAM with registered read port, inferable as block RAM.
- The control FSM, pointers and counts live in the top level.

## Test plan
- Reset, then hold `spi_start_aq` = 0 and pulse `sample_en` 10 times → `status_cnt` = 0, `aq_state` = 0, `aq_write_en` = 0.
- Assert start, then from edge n+3 write 32 samples of `antenna_data = 24'hA5A5A5 + i` → `status_cnt` = 32. Then 32 reads → data in order, `aq_read_valid` high for exactly 32 cycles, `status_cnt` = 0.
- Write 130 samples with no reads → `status_cnt` = 128, `aq_overflow` = 1, `aq_state` = HALTED. Reading 128 words returns only samples 0..127.
- At count 128, assert write and read together → count stays 128, `aq_overflow` = 0, and the new word appears after the 127 older ones.
- `aq_read_en` on empty for 5 cycles → `aq_read_valid` = 0, count 0, pointers unchanged. Then one write with a simultaneous read → count 1.
- With `AQ_TEST_PATTERN_EN`: 40 writes then 40 reads → data 0..39. Assert `rst` mid-stream → all outputs return to reset values, and the next write after restart yields 0.
